// File: rtl/lib_arbiter_pkg.sv
// Shared types for the pixel event requester: per-pixel FSM encoding and
// refractory-counter sizing helper.
package lib_arbiter_pkg;

    typedef enum logic [1:0] {
        PIX_IDLE    = 2'b00,
        PIX_REQ     = 2'b01,
        PIX_REFRACT = 2'b10
    } pix_state_t;

    localparam int REFRACT_CYC_DEF = 8;

    // Counter must hold REFRACT_CYC-1; never narrower than one bit.
    function automatic int cnt_bits(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pixel_req_cell.sv
// One pixel: IDLE -> REQ -> REFRACT -> IDLE, with polarity latch and
// refractory countdown. FSM state is exported on `state` for observation.
module pixel_req_cell
    import lib_arbiter_pkg::*;
#(
    parameter int REFRACT_CYC = REFRACT_CYC_DEF
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       evt,
    input  logic       pol,
    input  logic       enable,
    input  logic       gnt,
    output pix_state_t state,
    output logic       pol_q,
    output logic       drop,
    output logic       gnt_err
);

    localparam int RC_W = cnt_bits(REFRACT_CYC);
    localparam logic [RC_W-1:0] RC_LOAD = RC_W'((REFRACT_CYC == 0) ? 0 : REFRACT_CYC - 1);

    pix_state_t      state_q, state_d;
    logic [RC_W-1:0] cnt_q, cnt_d;
    logic            pol_d;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= PIX_IDLE;
            cnt_q   <= '0;
            pol_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pol_q   <= pol_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pol_d   = pol_q;
        drop    = 1'b0;
        gnt_err = 1'b0;
        case (state_q)
            PIX_IDLE: begin
                gnt_err = gnt;
                if (evt && enable) begin
                    state_d = PIX_REQ;
                    pol_d   = pol;
                end
            end
            PIX_REQ: begin
                // An event coinciding with the grant is still a drop.
                drop = evt && enable;
                if (gnt) begin
                    if (REFRACT_CYC == 0) begin
                        state_d = PIX_IDLE;
                    end else begin
                        state_d = PIX_REFRACT;
                        cnt_d   = RC_LOAD;
                    end
                end
            end
            PIX_REFRACT: begin
                gnt_err = gnt;
                drop    = evt && enable;
                if (cnt_q == '0) begin
                    state_d = PIX_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                gnt_err = gnt;
                state_d = PIX_IDLE;
            end
        endcase
    end

    assign state = state_q;

endmodule

// File: rtl/pixel_event_requester.sv
// Pixel-side requester for one arbitration group: array of pixel cells, grant
// checking with sticky err_o, optional saturating drop counter (EBC_DROP_CNT_EN).
module pixel_event_requester
    import lib_arbiter_pkg::*;
#(
    parameter int Lvl_ROWS    = 2,
    parameter int Lvl_COLS    = 2,
    parameter int REFRACT_CYC = REFRACT_CYC_DEF,
    parameter int CNT_W       = 8
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              enable_i,
    input  logic [Lvl_ROWS-1:0][Lvl_COLS-1:0] event_i,
    input  logic [Lvl_ROWS-1:0][Lvl_COLS-1:0] polarity_i,
    input  logic [Lvl_ROWS-1:0][Lvl_COLS-1:0] gnt_i,
    output logic [Lvl_ROWS-1:0][Lvl_COLS-1:0] req_o,
    output logic [Lvl_ROWS-1:0][Lvl_COLS-1:0] pol_o,
    output logic                              busy_o,
    output logic                              err_o,
    output logic [CNT_W-1:0]                  drop_cnt_o
);

    localparam int NPIX = Lvl_ROWS * Lvl_COLS;

    logic [NPIX-1:0] evt_v, pol_in_v, gnt_v;
    logic [NPIX-1:0] req_v, pol_v, drop_v, gnt_err_v;
    pix_state_t      pix_state [NPIX];
    logic            multi_gnt;
    logic            err_q;

    assign evt_v    = event_i;
    assign pol_in_v = polarity_i;
    assign gnt_v    = gnt_i;

    for (genvar g = 0; g < NPIX; g++) begin : g_pix
        pixel_req_cell #(
            .REFRACT_CYC(REFRACT_CYC)
        ) u_cell (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .evt     (evt_v[g]),
            .pol     (pol_in_v[g]),
            .enable  (enable_i),
            .gnt     (gnt_v[g]),
            .state   (pix_state[g]),
            .pol_q   (pol_v[g]),
            .drop    (drop_v[g]),
            .gnt_err (gnt_err_v[g])
        );
        assign req_v[g] = (pix_state[g] == PIX_REQ);
    end

    assign req_o  = req_v;
    assign pol_o  = pol_v;
    assign busy_o = |req_v;

    // Clearing the lowest set bit leaves something only if two or more are set.
    assign multi_gnt = |(gnt_v & (gnt_v - 1'b1));

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            err_q <= 1'b0;
        end else if (multi_gnt || (|gnt_err_v)) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;

`ifdef EBC_DROP_CNT_EN
    localparam int SUM_W = CNT_W + $clog2(NPIX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] drop_cnt_q;
    logic [SUM_W-1:0] drop_sum;

    always_comb begin
        drop_sum = SUM_W'(drop_cnt_q);
        for (int k = 0; k < NPIX; k++) begin
            drop_sum = drop_sum + SUM_W'(drop_v[k]);
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            drop_cnt_q <= '0;
        end else if (drop_sum > SUM_W'(CNT_MAX)) begin
            drop_cnt_q <= CNT_MAX;
        end else begin
            drop_cnt_q <= drop_sum[CNT_W-1:0];
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`else
    logic unused_drop;
    assign unused_drop = ^drop_v;
    assign drop_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_pixel_event_requester.sv
// Bench for pixel_event_requester: directed handshake/refractory/error steps
// plus random traffic, compared against a cycle-level behavioural model.
module tb_pixel_event_requester;

    localparam int REFRACT = 8;
    localparam int CNT_W   = 8;
    localparam int NPIX    = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk_i = 1'b0;
    logic             reset_i;
    logic             enable_i;
    logic [1:0][1:0]  event_i, polarity_i, gnt_i;
    logic [1:0][1:0]  req_o, pol_o;
    logic             busy_o, err_o;
    logic [CNT_W-1:0] drop_cnt_o;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: a pixel is requesting, or is blocked until m_free.
    bit m_req  [NPIX];
    bit m_pol  [NPIX];
    int m_free [NPIX];
    bit m_err;
    int m_drop;
    int cyc;

    pixel_event_requester #(
        .Lvl_ROWS(2), .Lvl_COLS(2), .REFRACT_CYC(REFRACT), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i),
        .event_i(event_i), .polarity_i(polarity_i), .gnt_i(gnt_i),
        .req_o(req_o), .pol_o(pol_o), .busy_o(busy_o), .err_o(err_o),
        .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
            $error("miscompare on %s", tag);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NPIX; i++) begin
            m_req[i] = 0; m_pol[i] = 0; m_free[i] = 0;
        end
        m_err  = 0;
        m_drop = 0;
    endtask

    task automatic model_clock(input logic [3:0] ev, input logic [3:0] pol,
                               input logic [3:0] gnt, input logic en);
        if ($countones(gnt) > 1) m_err = 1;
        for (int i = 0; i < NPIX; i++) begin
            if (m_req[i]) begin
                if (ev[i] && en) m_drop++;
                if (gnt[i]) begin
                    m_req[i]  = 0;
                    m_free[i] = cyc + 1 + REFRACT;
                end
            end else if (cyc < m_free[i]) begin
                if (gnt[i]) m_err = 1;
                if (ev[i] && en) m_drop++;
            end else begin
                if (gnt[i]) m_err = 1;
                if (ev[i] && en) begin
                    m_req[i] = 1;
                    m_pol[i] = pol[i];
                end
            end
        end
        cyc++;
    endtask

    function automatic logic [3:0] exp_req();
        logic [3:0] v;
        for (int i = 0; i < NPIX; i++) v[i] = m_req[i];
        return v;
    endfunction

    function automatic logic [3:0] exp_pol();
        logic [3:0] v;
        for (int i = 0; i < NPIX; i++) v[i] = m_req[i] & m_pol[i];
        return v;
    endfunction

    function automatic int exp_drop();
`ifdef EBC_DROP_CNT_EN
        return (m_drop > CNT_MAX) ? CNT_MAX : m_drop;
`else
        return 0;
`endif
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".req"},  32'(req_o), 32'(exp_req()));
        check({tag, ".pol"},  32'(pol_o & req_o), 32'(exp_pol()));
        check({tag, ".busy"}, 32'(busy_o), 32'(|exp_req()));
        check({tag, ".err"},  32'(err_o), 32'(m_err));
        check({tag, ".drop"}, 32'(drop_cnt_o), 32'(exp_drop()));
    endtask

    // Called just after a negedge; applies inputs for one rising edge.
    task automatic step(input string tag, input logic [3:0] ev, input logic [3:0] pol,
                        input logic [3:0] gnt, input logic en);
        event_i = ev; polarity_i = pol; gnt_i = gnt; enable_i = en;
        @(posedge clk_i);
        model_clock(ev, pol, gnt, en);
        @(negedge clk_i);
        check_all(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 4'h0, 4'h0, 4'h0, 1'b1);
    endtask

    // Asynchronous reset away from the clock edge, checked before any edge.
    task automatic async_reset(input string tag);
        #2 reset_i = 1'b0;
        #1;
        model_reset();
        check({tag, ".req_async"},  32'(req_o), 32'h0);
        check({tag, ".err_async"},  32'(err_o), 32'h0);
        check({tag, ".busy_async"}, 32'(busy_o), 32'h0);
        @(negedge clk_i);
        reset_i = 1'b1;
        check_all({tag, ".released"});
    endtask

    initial begin
        logic [3:0] ev, pol, gnt, pend;
        reset_i = 1'b0; enable_i = 1'b1;
        event_i = '0; polarity_i = '0; gnt_i = '0;
        cyc = 0;
        model_reset();
        repeat (2) @(negedge clk_i);
        reset_i = 1'b1;
        check_all("reset");

        // Reset while pixel[1][0] is requesting.
        step("rst_arm", 4'b0100, 4'b0100, 4'h0, 1'b1);
        async_reset("rst_mid");

        // Basic handshake on pixel[0][1].
        step("hs_evt", 4'b0010, 4'b0010, 4'h0, 1'b1);
        check("hs_req_direct", 32'(req_o), 32'h2);
        idle("hs_hold", 2);
        step("hs_gnt", 4'h0, 4'h0, 4'b0010, 1'b1);
        check("hs_req_dropped", 32'(req_o), 32'h0);

        // Refractory: events in first and last refractory cycles dropped.
        step("rf_first", 4'b0010, 4'b0010, 4'h0, 1'b1);
        idle("rf_mid", REFRACT - 2);
        step("rf_last", 4'b0010, 4'b0000, 4'h0, 1'b1);
        step("rf_rearm", 4'b0010, 4'b0000, 4'h0, 1'b1);
        check("rf_req_back", 32'(req_o), 32'h2);
`ifdef EBC_DROP_CNT_EN
        check("rf_two_drops", 32'(drop_cnt_o), 32'd2);
`endif
        step("rf_clear", 4'h0, 4'h0, 4'b0010, 1'b1);
        idle("rf_wait", REFRACT + 1);

        // All pixels at once, then served one at a time.
        step("all_evt", 4'hF, 4'b1010, 4'h0, 1'b1);
        check("all_req_f", 32'(req_o), 32'hF);
        for (int i = 0; i < NPIX; i++) step("all_serve", 4'h0, 4'h0, 4'(1 << i), 1'b1);
        check("all_busy_low", 32'(busy_o), 32'h0);
        idle("all_wait", REFRACT + 1);

        // Enable gating: held request survives, new events ignored, no drops.
        step("en_arm", 4'b1000, 4'b1000, 4'h0, 1'b1);
        step("en_off", 4'b0111, 4'b0111, 4'h0, 1'b0);
        step("en_off2", 4'b1111, 4'b0000, 4'h0, 1'b0);
        check("en_req_held", 32'(req_o), 32'h8);
        step("en_gnt", 4'h0, 4'h0, 4'b1000, 1'b0);
        idle("en_wait", REFRACT + 1);

        // Random traffic; grants are legal one-hot picks among pending pixels.
        for (int n = 0; n < 400; n++) begin
            ev   = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            pol  = 4'($urandom_range(0, 15));
            pend = exp_req();
            gnt  = 4'h0;
            if (pend != 0 && $urandom_range(0, 2) != 0) begin
                for (int t = 0; t < 8; t++) begin
                    int k;
                    k = $urandom_range(0, NPIX - 1);
                    if (pend[k] && gnt == 0) gnt = 4'(1 << k);
                end
            end
            step("rnd", ev, pol, gnt, ($urandom_range(0, 7) != 0));
        end

        // Protocol errors: multi-hot grant, then grant to an idle pixel.
        async_reset("err_rst1");
        step("err_multi", 4'h0, 4'h0, 4'b0011, 1'b1);
        check("err_multi_set", 32'(err_o), 32'h1);
        idle("err_sticky", 3);
        async_reset("err_rst2");
        step("err_idle_gnt", 4'h0, 4'h0, 4'b0100, 1'b1);
        check("err_idle_set", 32'(err_o), 32'h1);
        idle("err_sticky2", 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
